multi_cycle_control_unit: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS control decoder: one registered FSM sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Shares one ALU and one memory port, with a ready/request handshake to a variable-latency memory.
- Adds memory-timeout and illegal-instruction trapping.
- Sits between the instruction register (supplies Operator/Func) and the datapath muxes, register file, PC and memory.

---
 rtl/multi_cycle_control_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared ALU
// and memory port. Memory stalls are bounded by a timeout counter; illegal encodings and timeouts end in TRAP.
// state     | meaning
// FETCH   0 | read instruction at PC, PC += 4
// DECODE  1 | branch target into ALUOut, j/jal complete
// EXECUTE 2 | ALU op, address calc, branch/jr resolve
// MEMORY  3 | data access at ALUOut
// WRITEBK 4 | register file write
// TRAP    7 | fault, leaves only on Reset
module multi_cycle_control_unit #(
    parameter int MEM_TIMEOUT     = 16,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [5:0] Operator,
    input  logic [5:0] Func,
    input  logic       ALUZero,
    input  logic       MemReady,
    output logic       MemRequest,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       Signed,
    output logic       Shift,
    output logic [3:0] ALUControl,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg,
    output logic [2:0] State,
    output logic       Fault,
    output logic       InstrRetired
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_TRAP      = 3'd7;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;

    logic       is_rtype, is_jr, is_j, is_jal, is_lw, is_sw, is_beq, is_bne;
    logic       r_legal, r_shift, is_imm, is_addi, legal;
    logic [3:0] r_alu, imm_alu;
    logic       mem_wait, timeout_hit;

    assign is_rtype = (Operator == 6'b000000);
    assign is_jr    = is_rtype && (Func == 6'b001000);
    assign is_j     = (Operator == 6'b000010);
    assign is_jal   = (Operator == 6'b000011);
    assign is_lw    = (Operator == 6'b100011);
    assign is_sw    = (Operator == 6'b101011);
    assign is_beq   = (Operator == 6'b000100);
    assign is_bne   = (Operator == 6'b000101);
    assign is_addi  = (Operator == 6'b001000);

    always_comb begin
        r_legal = 1'b1;
        r_shift = 1'b0;
        r_alu   = ALU_ADD;
        case (Func)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b100110: r_alu = ALU_XOR;
            6'b000000: begin r_alu = ALU_SLL; r_shift = 1'b1; end
            6'b000010: begin r_alu = ALU_SRL; r_shift = 1'b1; end
            6'b000011: begin r_alu = ALU_SRA; r_shift = 1'b1; end
            6'b001000: r_alu = ALU_ADD;
            default:   r_legal = 1'b0;
        endcase
    end

    always_comb begin
        is_imm  = 1'b1;
        imm_alu = ALU_ADD;
        case (Operator)
            6'b001000, 6'b001001: imm_alu = ALU_ADD;
            6'b001100:            imm_alu = ALU_AND;
            6'b001101:            imm_alu = ALU_OR;
            6'b001110:            imm_alu = ALU_XOR;
            6'b001111:            imm_alu = ALU_LUI;
            default:              is_imm  = 1'b0;
        endcase
    end

    assign legal = is_rtype ? r_legal
                            : (is_imm || is_lw || is_sw || is_beq || is_bne || is_j || is_jal);

    // Both memory-facing states request every cycle, so "waiting" is simply not-ready there.
    assign mem_wait    = ((state_q == S_FETCH) || (state_q == S_MEMORY)) && !MemReady;
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait && (wait_q == WAIT_LAST);

    always_comb begin
        state_d      = state_q;
        MemRequest   = 1'b0;
        MemWrite     = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCSource     = 2'b00;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        Signed       = 1'b0;
        Shift        = 1'b0;
        ALUControl   = ALU_ADD;
        RegWrite     = 1'b0;
        RegDst       = 2'b00;
        MemToReg     = 2'b00;
        InstrRetired = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRequest = 1'b1;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                Signed  = 1'b1;
                if (is_j || is_jal) begin
                    PCWrite      = 1'b1;
                    PCSource     = 2'b10;
                    InstrRetired = 1'b1;
                    state_d      = S_FETCH;
                    if (is_jal) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemToReg = 2'b10;
                    end
                end else if (!legal) begin
                    if (TRAP_ON_ILLEGAL) begin
                        state_d = S_TRAP;
                    end else begin
                        InstrRetired = 1'b1;
                        state_d      = S_FETCH;
                    end
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_jr) begin
                    PCWrite      = 1'b1;
                    PCSource     = 2'b11;
                    InstrRetired = 1'b1;
                    state_d      = S_FETCH;
                end else if (is_rtype) begin
                    ALUSrcA    = 1'b1;
                    Shift      = r_shift;
                    ALUControl = r_alu;
                    state_d    = S_WRITEBACK;
                end else if (is_beq || is_bne) begin
                    ALUSrcA      = 1'b1;
                    ALUControl   = ALU_SUB;
                    PCSource     = 2'b01;
                    PCWrite      = is_beq ? ALUZero : !ALUZero;
                    InstrRetired = 1'b1;
                    state_d      = S_FETCH;
                end else if (is_lw || is_sw) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    Signed  = 1'b1;
                    state_d = S_MEMORY;
                end else begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    Signed     = is_addi;
                    ALUControl = imm_alu;
                    state_d    = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                MemRequest = 1'b1;
                IorD       = 1'b1;
                MemWrite   = is_sw;
                if (MemReady) begin
                    if (is_sw) begin
                        InstrRetired = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_WRITEBACK: begin
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
                RegDst       = is_rtype ? 2'b00 : 2'b01;
                MemToReg     = is_lw ? 2'b01 : 2'b00;
                state_d      = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_wait) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end

        if (Reset) begin
            state_d      = S_FETCH;
            wait_d       = '0;
            MemRequest   = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            PCWrite      = 1'b0;
            RegWrite     = 1'b0;
            InstrRetired = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        state_q <= state_d;
        wait_q  <= wait_d;
    end

    assign State = state_q;
    assign Fault = (state_q == S_TRAP);

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Random instruction stream with random memory latency against a per-instruction phase model
// of the control unit; traps and resets are folded into the stream.
module tb_multi_cycle_control_unit;

    localparam int TO = 4;

    localparam logic [3:0] C_R = 4'd0, C_JR = 4'd1, C_IMM = 4'd2, C_LW = 4'd3, C_SW = 4'd4,
                           C_BEQ = 4'd5, C_BNE = 4'd6, C_J = 4'd7, C_JAL = 4'd8, C_ILL = 4'd9;

    typedef struct packed {
        logic [2:0] state;
        logic       fault;
        logic       mem_req;
        logic       mem_wr;
        logic       iord;
        logic       ir_wr;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       src_a;
        logic [1:0] src_b;
        logic       sgn;
        logic       shf;
        logic [3:0] alu;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] m2r;
        logic       retired;
    } ctl_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] func;
        logic [3:0] cls;
        logic [3:0] alu;
        logic       shf;
        logic       sgn;
    } entry_t;

    logic       Clock, Reset, ALUZero, MemReady;
    logic [5:0] Operator, Func;
    logic       MemRequest, MemWrite, IorD, IRWrite, PCWrite, ALUSrcA, Signed, Shift;
    logic       RegWrite, Fault, InstrRetired;
    logic [1:0] PCSource, ALUSrcB, RegDst, MemToReg;
    logic [3:0] ALUControl;
    logic [2:0] State;

    int vectors = 0;
    int miscompares = 0;
    entry_t tbl[$];

    multi_cycle_control_unit #(.MEM_TIMEOUT(TO), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .Clock(Clock), .Reset(Reset), .Operator(Operator), .Func(Func),
        .ALUZero(ALUZero), .MemReady(MemReady), .MemRequest(MemRequest),
        .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .Signed(Signed),
        .Shift(Shift), .ALUControl(ALUControl), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemToReg(MemToReg), .State(State), .Fault(Fault), .InstrRetired(InstrRetired)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic ctl_t observe();
        ctl_t o;
        o = '{State, Fault, MemRequest, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA,
              ALUSrcB, Signed, Shift, ALUControl, RegWrite, RegDst, MemToReg, InstrRetired};
        return o;
    endfunction

    function automatic void add_entry(input logic [5:0] op, input logic [5:0] func,
                                      input logic [3:0] cls, input logic [3:0] alu,
                                      input logic shf, input logic sgn);
        entry_t e;
        e = '{op, func, cls, alu, shf, sgn};
        tbl.push_back(e);
    endfunction

    function automatic entry_t lookup(input logic [5:0] op, input logic [5:0] func);
        entry_t e;
        e = '{op, func, C_ILL, 4'b0000, 1'b0, 1'b0};
        foreach (tbl[i]) begin
            if (tbl[i].op == op && (op != 6'b000000 || tbl[i].func == func)) e = tbl[i];
        end
        return e;
    endfunction

    // One clock: drive the cycle's inputs, compare all outputs, advance to the next cycle.
    task automatic cyc(input string tag, input logic rdy, input logic zero, input ctl_t exp);
        MemReady = rdy;
        ALUZero  = zero;
        #1;
        check(tag, observe(), exp);
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        MemReady = 1'b1;
        ALUZero  = 1'($urandom);
        #1;
        check("rst_strobes", 26'({MemRequest, MemWrite, IRWrite, PCWrite, RegWrite, InstrRetired}), 26'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        check("rst_state", 26'({State, Fault, RegWrite}), 26'd0);
    endtask

    task automatic trap_then_reset();
        ctl_t x;
        x = '0;
        x.state = 3'd7;
        x.fault = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Operator = 6'($urandom);
            Func     = 6'($urandom);
            cyc("trap", 1'($urandom), 1'($urandom), x);
        end
        do_reset();
    endtask

    // Runs one instruction: wf/wm are memory wait cycles in FETCH/MEMORY; rst_mem aborts lw/sw in MEMORY.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] func, input int wf,
                             input int wm, input logic zero, input bit rst_mem);
        entry_t e;
        ctl_t   x;
        e = lookup(op, func);

        for (int i = 0; i < wf; i++) begin
            Operator = 6'($urandom);
            Func     = 6'($urandom);
            x = '0;
            x.mem_req = 1'b1;
            cyc("fetch_wait", 1'b0, 1'($urandom), x);
            if (i == TO - 1) begin
                trap_then_reset();
                return;
            end
        end
        Operator = 6'($urandom);
        Func     = 6'($urandom);
        x = '0;
        x.mem_req = 1'b1;
        x.ir_wr   = 1'b1;
        x.pc_wr   = 1'b1;
        x.src_b   = 2'b01;
        cyc("fetch_done", 1'b1, 1'($urandom), x);

        Operator = op;
        Func     = func;
        x = '0;
        x.state = 3'd1;
        x.src_b = 2'b11;
        x.sgn   = 1'b1;
        if (e.cls == C_J || e.cls == C_JAL) begin
            x.pc_wr   = 1'b1;
            x.pc_src  = 2'b10;
            x.retired = 1'b1;
        end
        if (e.cls == C_JAL) begin
            x.reg_wr  = 1'b1;
            x.reg_dst = 2'b10;
            x.m2r     = 2'b10;
        end
        cyc("decode", 1'($urandom), 1'($urandom), x);
        if (e.cls == C_J || e.cls == C_JAL) return;
        if (e.cls == C_ILL) begin
            trap_then_reset();
            return;
        end

        x = '0;
        x.state = 3'd2;
        case (e.cls)
            C_JR: begin
                x.pc_wr   = 1'b1;
                x.pc_src  = 2'b11;
                x.retired = 1'b1;
            end
            C_R: begin
                x.src_a = 1'b1;
                x.shf   = e.shf;
                x.alu   = e.alu;
            end
            C_IMM: begin
                x.src_a = 1'b1;
                x.src_b = 2'b10;
                x.sgn   = e.sgn;
                x.alu   = e.alu;
            end
            C_LW, C_SW: begin
                x.src_a = 1'b1;
                x.src_b = 2'b10;
                x.sgn   = 1'b1;
            end
            default: begin
                x.src_a   = 1'b1;
                x.alu     = 4'b0001;
                x.pc_src  = 2'b01;
                x.pc_wr   = (e.cls == C_BEQ) ? zero : !zero;
                x.retired = 1'b1;
            end
        endcase
        cyc("execute", 1'($urandom), zero, x);
        if (e.cls == C_JR || e.cls == C_BEQ || e.cls == C_BNE) return;

        if (e.cls == C_LW || e.cls == C_SW) begin
            for (int i = 0; i < wm; i++) begin
                x = '0;
                x.state   = 3'd3;
                x.mem_req = 1'b1;
                x.iord    = 1'b1;
                x.mem_wr  = (e.cls == C_SW);
                cyc("mem_wait", 1'b0, 1'($urandom), x);
                if (i == TO - 1) begin
                    trap_then_reset();
                    return;
                end
            end
            if (rst_mem) begin
                do_reset();
                return;
            end
            x = '0;
            x.state   = 3'd3;
            x.mem_req = 1'b1;
            x.iord    = 1'b1;
            x.mem_wr  = (e.cls == C_SW);
            x.retired = (e.cls == C_SW);
            cyc("mem_done", 1'b1, 1'($urandom), x);
            if (e.cls == C_SW) return;
        end

        x = '0;
        x.state   = 3'd4;
        x.reg_wr  = 1'b1;
        x.retired = 1'b1;
        x.reg_dst = (e.cls == C_R) ? 2'b00 : 2'b01;
        x.m2r     = (e.cls == C_LW) ? 2'b01 : 2'b00;
        cyc("writeback", 1'($urandom), 1'($urandom), x);
    endtask

    initial begin
        entry_t e;
        logic [5:0] op, fn;
        int wf, wm;

        add_entry(6'b000000, 6'b100000, C_R,   4'b0000, 1'b0, 1'b0);
        add_entry(6'b000000, 6'b100010, C_R,   4'b0001, 1'b0, 1'b0);
        add_entry(6'b000000, 6'b100100, C_R,   4'b0010, 1'b0, 1'b0);
        add_entry(6'b000000, 6'b100101, C_R,   4'b0011, 1'b0, 1'b0);
        add_entry(6'b000000, 6'b100110, C_R,   4'b0100, 1'b0, 1'b0);
        add_entry(6'b000000, 6'b000000, C_R,   4'b0101, 1'b1, 1'b0);
        add_entry(6'b000000, 6'b000010, C_R,   4'b0111, 1'b1, 1'b0);
        add_entry(6'b000000, 6'b000011, C_R,   4'b1111, 1'b1, 1'b0);
        add_entry(6'b000000, 6'b001000, C_JR,  4'b0000, 1'b0, 1'b0);
        add_entry(6'b001000, 6'b000000, C_IMM, 4'b0000, 1'b0, 1'b1);
        add_entry(6'b001001, 6'b000000, C_IMM, 4'b0000, 1'b0, 1'b0);
        add_entry(6'b001100, 6'b000000, C_IMM, 4'b0010, 1'b0, 1'b0);
        add_entry(6'b001101, 6'b000000, C_IMM, 4'b0011, 1'b0, 1'b0);
        add_entry(6'b001110, 6'b000000, C_IMM, 4'b0100, 1'b0, 1'b0);
        add_entry(6'b001111, 6'b000000, C_IMM, 4'b0110, 1'b0, 1'b0);
        add_entry(6'b100011, 6'b000000, C_LW,  4'b0000, 1'b0, 1'b0);
        add_entry(6'b101011, 6'b000000, C_SW,  4'b0000, 1'b0, 1'b0);
        add_entry(6'b000100, 6'b000000, C_BEQ, 4'b0000, 1'b0, 1'b0);
        add_entry(6'b000101, 6'b000000, C_BNE, 4'b0000, 1'b0, 1'b0);
        add_entry(6'b000010, 6'b000000, C_J,   4'b0000, 1'b0, 1'b0);
        add_entry(6'b000011, 6'b000000, C_JAL, 4'b0000, 1'b0, 1'b0);

        Reset    = 1'b1;
        Operator = '0;
        Func     = '0;
        ALUZero  = 1'b0;
        MemReady = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        do_reset();

        run_instr(6'b000000, 6'b100000, 0, 0, 1'b0, 1'b0);   // add
        run_instr(6'b100011, 6'b000000, 0, 3, 1'b0, 1'b0);   // lw, 3 wait cycles
        run_instr(6'b000100, 6'b000000, 0, 0, 1'b0, 1'b0);   // beq not taken
        run_instr(6'b000101, 6'b000000, 0, 0, 1'b0, 1'b0);   // bne taken
        run_instr(6'b000011, 6'b000000, 0, 0, 1'b0, 1'b0);   // jal
        run_instr(6'b000000, 6'b100000, TO, 0, 1'b0, 1'b0);  // fetch timeout
        run_instr(6'b000000, 6'b100000, TO - 1, 0, 1'b0, 1'b0);
        run_instr(6'b111111, 6'b000000, 0, 0, 1'b0, 1'b0);   // illegal opcode
        run_instr(6'b100011, 6'b000000, 0, 1, 1'b0, 1'b1);   // reset mid-MEMORY
        run_instr(6'b101011, 6'b000000, 1, TO, 1'b0, 1'b0);  // memory timeout
        run_instr(6'b000000, 6'b001000, 0, 0, 1'b0, 1'b0);   // jr

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) < 8) begin
                e  = tbl[$urandom_range(0, tbl.size() - 1)];
                op = e.op;
                fn = (e.op == 6'b000000) ? e.func : 6'($urandom);
            end else begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end
            wf = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, TO - 1);
            wm = ($urandom_range(0, 11) == 0) ? TO : $urandom_range(0, TO - 1);
            run_instr(op, fn, wf, wm, 1'($urandom), ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
